spi_slave_shifter: RTL and testbench
====================================

# spi_slave_shifter

SPI target-side shift engine: the far end of the APB SPI master's shift register. It oversamples external `sclk`/`ss_n`/`mosi` on `pclk`, and supports all four CPOL/CPHA modes and MSB- or LSB-first order. It serializes a buffered transmit byte onto `miso` and deserializes `mosi` into a receive byte with a valid/ack handshake. It sits between the SPI pins and the target's APB register block.

## Interface
- Parameters:
- `DATA_W`, 8, frame width in bits.
- Ports (clock/reset: preset_n, asynchronous, active-low; clock pclk):
- `pclk`  in  1  system clock; `sclk` ≤ pclk/4.
- `preset_n`  in  1  asynchronous active-low reset.
- `cpol`, `cpha`, `lsbfe`  in  1 each  mode config; latched at `ss_n` assertion.
- `sclk_in`, `ss_n_in`, `mosi_in`  in  1 each  asynchronous pins.
- `miso`  out  1  serial data out.
- `miso_oe`  out  1  pad output enable.
- `tx_data`  in  DATA_W  next byte to send.
- `tx_valid`  in  1  `tx_data` offered.
- `tx_ready`  out  1  1-entry TX buffer empty.
- `rx_data`  out  DATA_W  last received byte.
- `rx_valid`  out  1  level; `rx_data` unread.
- `rx_ack`  in  1  consumer read; clears `rx_valid`.
- `status_clr`  in  1  clears sticky flags.
- `rx_overrun`, `tx_underrun`  out  1 each  sticky error flags.
- `busy`  out  1  frame in progress.

## Operation
- All three pins pass through a 2-flop synchronizer plus one delay flop. Edges are detected from synchronizer stage 2 vs. the delay flop.
- Leading `sclk` edge = transition away from `cpol`. Trailing edge = return to `cpol`.
- Sample edge: leading edge if `cpha`=0, trailing edge if `cpha`=1. Shift edge: the other one.
- States:
  - IDLE: `ss_n` high. `miso_oe`=0, bit count 0.
  - ACTIVE: `ss_n` low.
- IDLE→ACTIVE on synchronized `ss_n` fall:
  - Latch `cpol`/`cpha`/`lsbfe`.
  - Load the TX shift register from the buffer if full, and empty the buffer.
  - If the buffer is empty, load 0x00 and set `tx_underrun`.
  - Assert `miso_oe`.
  - `cpha`=0: drive the first bit (bit 7, or bit 0 if `lsbfe`) immediately.
  - `cpha`=1: drive the first bit on the first shift edge.
- ACTIVE behaviour:
  - Each sample edge shifts `mosi` into the RX register and increments the bit counter.
  - Each shift edge presents the next TX bit. With `cpha`=0, the shift edge after the 8th sample instead loads the next byte (buffer or underrun rule) and drives its first bit.
  - On the 8th sample edge: `rx_data` ← assembled byte, `rx_valid`=1, counter wraps to 0. Frames continue back-to-back while `ss_n` stays low.
- ACTIVE→IDLE on synchronized `ss_n` rise:
  - Any partial byte is discarded; no `rx_valid`.
  - Counter is cleared and `miso_oe` drops.
  - The TX shift register contents are lost; the buffer is untouched.
- Handshakes:
  - TX buffer accepts on `tx_valid && tx_ready`.
  - Byte completes while `rx_valid`=1: `rx_data` is overwritten and `rx_overrun` is set.
  - `rx_ack` in the same cycle as a completion: the new byte wins and `rx_valid` stays 1.
- `status_clr` clears both sticky flags. A set event in the same cycle wins.
- Config changes while ACTIVE are ignored until the next `ss_n` fall.

## Timing
- Reset values: `miso`=0, `miso_oe`=0, `tx_ready`=1, `rx_data`=0, `rx_valid`=0, `rx_overrun`=0, `tx_underrun`=0, `busy`=0. Synchronizers reset to idle levels: `ss_n`=1; `sclk` reset level = `cpol`.
- Pin-to-action latency is 3 pclk:
  - A pin edge before pclk edge 0 is acted on at pclk edge 3.
  - `rx_valid` rises at edge 3 after the 8th sample pin edge.
  - `miso` changes at edge 3 after the shift pin edge.
  - `miso_oe`/`busy` assert at edge 3 after the `ss_n` fall.
- `tx_ready` deasserts the cycle after acceptance. It reasserts the cycle after the byte is loaded.
- `rx_valid` clears the cycle after `rx_ack`.
- Reset mid-frame: all outputs go to reset values immediately (async). The buffer is emptied.

## Structure
- Package `spi_pkg`: `DATA_W` default, state enum `{SPI_IDLE, SPI_ACTIVE}`, mode encoding type.
- Sub-module `spi_sync_edge`: 2-flop sync + delay flop, outputting level, rise and fall. Instantiated three times.

## Test plan
- Mode 0, MSB-first:
  - Stimulus: `tx_data`=0xA5 queued; master sends 0x3C.
  - Response: `miso` bits 1,0,1,0,0,1,0,1; `rx_data`=0x3C; `rx_valid`=1, 3 pclk after the 8th rising `sclk`.
- Mode 3, LSB-first:
  - Stimulus: `tx_data`=0x81; master sends 0x01.
  - Response: `miso` sequence 1,0,0,0,0,0,0,1; `rx_data`=0x80.
- Back-to-back and overrun:
  - Stimulus: two bytes 0x11, 0x22 under one `ss_n`, second TX byte not queued, no `rx_ack`.
  - Response: second `miso` byte 0x00; `tx_underrun`=1; `rx_data`=0x22; `rx_overrun`=1.
- Abort:
  - Stimulus: `ss_n` rises after 5 bits.
  - Response: no `rx_valid`; `miso_oe`=0 within 3 pclk; the next frame receives a full 8 bits correctly.
- Reset mid-frame:
  - Stimulus: `preset_n` pulsed low during bit 4.
  - Response: all outputs at reset values in the same cycle; `tx_ready`=1.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Purpose  : Shared types and constants for the SPI target-side shift engine.
//            Mode encoding is {cpol, cpha}; the latched per-frame config
//            bundles the mode with the bit-order select.
// Revision : 1.0  initial release
// ============================================================================
package spi_pkg;

  localparam int c_SPI_DATA_W = 8;

  typedef enum logic [0:0] {
    SPI_IDLE   = 1'b0,
    SPI_ACTIVE = 1'b1
  } spi_state_e;

  typedef enum logic [1:0] {
    SPI_MODE0 = 2'b00,
    SPI_MODE1 = 2'b01,
    SPI_MODE2 = 2'b10,
    SPI_MODE3 = 2'b11
  } spi_mode_e;

  typedef struct packed {
    spi_mode_e mode;
    logic      lsbfe;
  } spi_cfg_t;

  function automatic logic spi_cpol(input spi_mode_e m);
    logic [1:0] v;
    v = m;
    return v[1];
  endfunction

  function automatic logic spi_cpha(input spi_mode_e m);
    logic [1:0] v;
    v = m;
    return v[0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : spi_sync_edge
// Purpose  : Two-flop synchronizer plus one delay flop for an asynchronous
//            pin. Edges are detected between stage 2 and the delay flop and
//            registered, so an event reaches the consumer together with the
//            matching delayed level.
// Ports    : pclk, preset_n   clock / async active-low reset
//            rst_lvl          level the chain resets to (pin idle level)
//            pin              asynchronous input
//            level            synchronized, delayed level
//            rise, fall       one-cycle edge pulses aligned with level
// Revision : 1.0  initial release
// ============================================================================
module spi_sync_edge (
  input  logic pclk,
  input  logic preset_n,
  input  logic rst_lvl,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic r_s1;
  logic r_s2;
  logic r_dly;
  logic r_rise;
  logic r_fall;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_s1   <= rst_lvl;
      r_s2   <= rst_lvl;
      r_dly  <= rst_lvl;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_s1   <= pin;
      r_s2   <= r_s1;
      r_dly  <= r_s2;
      r_rise <= r_s2 & ~r_dly;
      r_fall <= ~r_s2 & r_dly;
    end
  end

  assign level = r_dly;
  assign rise  = r_rise;
  assign fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/spi_slave_shifter.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_shifter
// Purpose  : SPI target shift engine. Oversamples sclk/ss_n/mosi on pclk,
//            supports CPOL/CPHA modes 0-3 and MSB/LSB-first order, with a
//            one-entry TX buffer and a valid/ack RX register.
// Ports    : pclk, preset_n            clock / async active-low reset
//            cpol, cpha, lsbfe         mode config, latched at ss_n fall
//            sclk_in, ss_n_in, mosi_in asynchronous SPI pins
//            miso, miso_oe             serial out and pad enable
//            tx_data/tx_valid/tx_ready TX buffer write handshake
//            rx_data/rx_valid/rx_ack   RX byte and read handshake
//            status_clr                clears rx_overrun / tx_underrun
//            busy                      frame in progress
// Revision : 1.0  initial release
// ============================================================================
module spi_slave_shifter
  import spi_pkg::*;
#(
  parameter int DATA_W = c_SPI_DATA_W
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsbfe,
  input  logic              sclk_in,
  input  logic              ss_n_in,
  input  logic              mosi_in,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  input  logic              status_clr,
  output logic              rx_overrun,
  output logic              tx_underrun,
  output logic              busy
);

  localparam int                 c_CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DATA_W - 1);

  // Bit to present on miso for position idx of a frame.
  function automatic logic tx_bit(input logic [DATA_W-1:0]  b,
                                  input logic [c_CNT_W-1:0] idx,
                                  input logic               lsb);
    logic [c_CNT_W-1:0] pos;
    pos = lsb ? idx : (c_LAST - idx);
    return b[pos];
  endfunction

  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_ss_lvl, w_ss_rise, w_ss_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall;
  logic w_unused;

  // sclk resets to its idle level so no phantom edge follows reset.
  spi_sync_edge u_sync_sclk (
    .pclk(pclk), .preset_n(preset_n), .rst_lvl(cpol), .pin(sclk_in),
    .level(w_sclk_lvl), .rise(w_sclk_rise), .fall(w_sclk_fall)
  );
  spi_sync_edge u_sync_ss (
    .pclk(pclk), .preset_n(preset_n), .rst_lvl(1'b1), .pin(ss_n_in),
    .level(w_ss_lvl), .rise(w_ss_rise), .fall(w_ss_fall)
  );
  spi_sync_edge u_sync_mosi (
    .pclk(pclk), .preset_n(preset_n), .rst_lvl(1'b0), .pin(mosi_in),
    .level(w_mosi), .rise(w_mosi_rise), .fall(w_mosi_fall)
  );

  assign w_unused = &{1'b0, w_sclk_lvl, w_ss_lvl, w_mosi_rise, w_mosi_fall};

  spi_state_e         r_state;
  spi_cfg_t           r_cfg;
  logic [c_CNT_W-1:0] r_cnt;
  logic [DATA_W-1:0]  r_rx_shift;
  logic [DATA_W-1:0]  r_tx_shift;
  logic [DATA_W-1:0]  r_tx_buf;
  logic [DATA_W-1:0]  r_rx_data;
  logic               r_tx_full;
  logic               r_tx_pend;   // shift reg holds a byte whose first bit is not yet driven
  logic               r_miso;
  logic               r_rx_valid;
  logic               r_rx_overrun;
  logic               r_tx_underrun;

  logic              w_cpol, w_cpha;
  logic              w_lead, w_trail, w_sample, w_shift;
  logic              w_active;
  logic              w_rx_done, w_tx_load, w_tx_accept;
  logic [DATA_W-1:0] w_load_byte, w_rx_next;

  assign w_cpol   = spi_cpol(r_cfg.mode);
  assign w_cpha   = spi_cpha(r_cfg.mode);
  assign w_lead   = w_cpol ? w_sclk_fall : w_sclk_rise;
  assign w_trail  = w_cpol ? w_sclk_rise : w_sclk_fall;
  assign w_sample = w_cpha ? w_trail : w_lead;
  assign w_shift  = w_cpha ? w_lead  : w_trail;

  // An ss_n rise in the same cycle as an sclk event ends the frame first.
  assign w_active    = (r_state == SPI_ACTIVE) && !w_ss_rise;
  assign w_rx_done   = w_active && w_sample && (r_cnt == c_LAST);
  assign w_tx_load   = ((r_state == SPI_IDLE) && w_ss_fall) ||
                       (w_active && w_shift && (r_cnt == '0) && !r_tx_pend);
  assign w_tx_accept = tx_valid && !r_tx_full;
  assign w_load_byte = r_tx_full ? r_tx_buf : '0;
  assign w_rx_next   = r_cfg.lsbfe ? {w_mosi, r_rx_shift[DATA_W-1:1]}
                                   : {r_rx_shift[DATA_W-2:0], w_mosi};

  // Frame sequencing and serializer.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_state    <= SPI_IDLE;
      r_cfg      <= '0;
      r_cnt      <= '0;
      r_rx_shift <= '0;
      r_tx_shift <= '0;
      r_tx_pend  <= 1'b0;
      r_miso     <= 1'b0;
    end else begin
      case (r_state)
        SPI_IDLE: begin
          r_cnt  <= '0;
          r_miso <= 1'b0;
          if (w_ss_fall) begin
            r_state    <= SPI_ACTIVE;
            r_cfg      <= '{mode: spi_mode_e'({cpol, cpha}), lsbfe: lsbfe};
            r_tx_shift <= w_load_byte;
            r_tx_pend  <= cpha;
            if (!cpha) begin
              r_miso <= tx_bit(w_load_byte, '0, lsbfe);
            end
          end
        end
        SPI_ACTIVE: begin
          if (w_ss_rise) begin
            r_state   <= SPI_IDLE;
            r_cnt     <= '0;
            r_miso    <= 1'b0;
            r_tx_pend <= 1'b0;
          end else begin
            if (w_sample) begin
              r_rx_shift <= w_rx_next;
              r_cnt      <= (r_cnt == c_LAST) ? '0 : r_cnt + c_CNT_W'(1);
            end
            if (w_shift) begin
              // Count back at zero with nothing pending means a byte
              // boundary: fetch the next byte and drive its first bit.
              if ((r_cnt == '0) && !r_tx_pend) begin
                r_tx_shift <= w_load_byte;
                r_miso     <= tx_bit(w_load_byte, '0, r_cfg.lsbfe);
              end else begin
                r_miso <= tx_bit(r_tx_shift, r_cnt, r_cfg.lsbfe);
              end
              r_tx_pend <= 1'b0;
            end
          end
        end
        default: r_state <= SPI_IDLE;
      endcase
    end
  end

  // TX buffer, RX register and sticky flags.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_tx_buf      <= '0;
      r_tx_full     <= 1'b0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_rx_overrun  <= 1'b0;
      r_tx_underrun <= 1'b0;
    end else begin
      // Accept only happens when empty, so a load in the same cycle has
      // nothing to consume and the accepted byte survives.
      if (w_tx_accept) begin
        r_tx_buf  <= tx_data;
        r_tx_full <= 1'b1;
      end else if (w_tx_load) begin
        r_tx_full <= 1'b0;
      end

      if (w_rx_done) begin
        r_rx_data  <= w_rx_next;
        r_rx_valid <= 1'b1;
      end else if (rx_ack) begin
        r_rx_valid <= 1'b0;
      end

      // A same-cycle ack means the old byte was consumed, so nothing is lost.
      if (w_rx_done && r_rx_valid && !rx_ack) begin
        r_rx_overrun <= 1'b1;
      end else if (status_clr) begin
        r_rx_overrun <= 1'b0;
      end

      if (w_tx_load && !r_tx_full) begin
        r_tx_underrun <= 1'b1;
      end else if (status_clr) begin
        r_tx_underrun <= 1'b0;
      end
    end
  end

  assign miso        = r_miso;
  assign miso_oe     = (r_state == SPI_ACTIVE);
  assign busy        = (r_state == SPI_ACTIVE);
  assign tx_ready    = !r_tx_full;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign rx_overrun  = r_rx_overrun;
  assign tx_underrun = r_tx_underrun;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_shifter
// Purpose  : Directed self-checking bench for spi_slave_shifter. A simple
//            SPI master task drives the pins (always MSB-first on the wire)
//            and collects miso in wire order.
// Revision : 1.0  initial release
// ============================================================================
module tb_spi_slave_shifter;

  localparam int H = 5;  // sclk half period in pclk cycles

  logic       pclk       = 1'b0;
  logic       preset_n   = 1'b0;
  logic       cpol       = 1'b0;
  logic       cpha       = 1'b0;
  logic       lsbfe      = 1'b0;
  logic       sclk_in    = 1'b0;
  logic       ss_n_in    = 1'b1;
  logic       mosi_in    = 1'b0;
  logic [7:0] tx_data    = 8'h00;
  logic       tx_valid   = 1'b0;
  logic       rx_ack     = 1'b0;
  logic       status_clr = 1'b0;
  logic       miso, miso_oe, tx_ready, rx_valid, rx_overrun, tx_underrun, busy;
  logic [7:0] rx_data;

  spi_slave_shifter #(.DATA_W(8)) dut (
    .pclk(pclk), .preset_n(preset_n),
    .cpol(cpol), .cpha(cpha), .lsbfe(lsbfe),
    .sclk_in(sclk_in), .ss_n_in(ss_n_in), .mosi_in(mosi_in),
    .miso(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .status_clr(status_clr),
    .rx_overrun(rx_overrun), .tx_underrun(tx_underrun), .busy(busy)
  );

  always #5 pclk = ~pclk;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_sample_cyc = 0;
  int   rv_rise_cyc = 0;
  logic rv_q = 1'b0;

  always @(posedge pclk) cyc <= cyc + 1;

  // Records the posedge count at which rx_valid was first seen high.
  always @(negedge pclk) begin
    if (rx_valid && !rv_q) rv_rise_cyc = cyc;
    rv_q = rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic push_tx(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    wait_n(1);
    tx_valid = 1'b0;
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    wait_n(1);
    rx_ack = 1'b0;
  endtask

  task automatic pulse_clr();
    status_clr = 1'b1;
    wait_n(1);
    status_clr = 1'b0;
  endtask

  // Master: sends nbits of mo MSB-first, returns miso bits in wire order.
  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi_in = mo[7-i];
        wait_n(H);
        mi[7-i] = miso;
        sclk_in = ~cpol;
        last_sample_cyc = cyc;
        wait_n(H);
        sclk_in = cpol;
      end else begin
        sclk_in = ~cpol;
        mosi_in = mo[7-i];
        wait_n(H);
        mi[7-i] = miso;
        sclk_in = cpol;
        last_sample_cyc = cyc;
        wait_n(H);
      end
    end
    wait_n(H);
  endtask

  logic [7:0] mi;

  initial begin
    // ---------------- reset ----------------
    wait_n(2);
    chk("reset_flags", 32'({miso, miso_oe, tx_ready, rx_valid, rx_overrun, tx_underrun, busy}),
        32'b0010000);
    chk("reset_rx_data", 32'(rx_data), 32'h00);
    preset_n = 1'b1;
    wait_n(4);

    // ---------------- mode 0, MSB-first ----------------
    push_tx(8'hA5);
    chk("t1_tx_ready_full", 32'(tx_ready), 0);
    ss_n_in = 1'b0;
    wait_n(3);
    chk("t1_oe_before_edge3", 32'(miso_oe), 0);
    wait_n(1);
    chk("t1_oe_busy", 32'({miso_oe, busy}), 32'b11);
    chk("t1_first_bit", 32'(miso), 1);
    chk("t1_tx_ready_reload", 32'(tx_ready), 1);
    wait_n(2);
    xfer(8'h3C, 8, mi);
    chk("t1_miso_byte", 32'(mi), 32'hA5);
    chk("t1_rx_data", 32'(rx_data), 32'h3C);
    chk("t1_rx_valid", 32'(rx_valid), 1);
    // Pin driven between posedges; edge 3 is the 4th posedge after that.
    chk("t1_rx_latency", 32'(rv_rise_cyc - last_sample_cyc), 4);
    // Trailing edge after the 8th sample fetched from an empty buffer.
    chk("t1_underrun", 32'(tx_underrun), 1);
    ss_n_in = 1'b1;
    wait_n(5);
    chk("t1_oe_off", 32'({miso_oe, busy}), 0);
    pulse_ack();
    chk("t1_rx_valid_ack", 32'(rx_valid), 0);
    pulse_clr();
    chk("t1_underrun_clr", 32'(tx_underrun), 0);

    // ---------------- mode 3, LSB-first ----------------
    cpol = 1'b1; cpha = 1'b1; lsbfe = 1'b1;
    sclk_in = 1'b1;
    wait_n(6);
    push_tx(8'h81);
    ss_n_in = 1'b0;
    wait_n(6);
    chk("t2_miso_before_shift", 32'(miso), 0);
    xfer(8'h01, 8, mi);
    chk("t2_miso_seq", 32'(mi), 32'h81);
    chk("t2_rx_data", 32'(rx_data), 32'h80);
    chk("t2_rx_valid", 32'(rx_valid), 1);
    chk("t2_no_underrun", 32'(tx_underrun), 0);
    ss_n_in = 1'b1;
    wait_n(5);
    pulse_ack();

    // ---------------- back-to-back, underrun, overrun ----------------
    cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0;
    sclk_in = 1'b0;
    wait_n(6);
    push_tx(8'h5A);
    ss_n_in = 1'b0;
    wait_n(6);
    xfer(8'h11, 8, mi);
    chk("t3_miso_b0", 32'(mi), 32'h5A);
    chk("t3_rx_data_b0", 32'(rx_data), 32'h11);
    chk("t3_flags_b0", 32'({rx_overrun, tx_underrun}), 32'b01);
    xfer(8'h22, 8, mi);
    chk("t3_miso_b1", 32'(mi), 32'h00);
    chk("t3_rx_data_b1", 32'(rx_data), 32'h22);
    chk("t3_flags_b1", 32'({rx_overrun, tx_underrun}), 32'b11);
    ss_n_in = 1'b1;
    wait_n(5);
    pulse_clr();
    chk("t3_flags_clr", 32'({rx_overrun, tx_underrun}), 0);
    pulse_ack();

    // ---------------- abort after 5 bits ----------------
    push_tx(8'hC3);
    ss_n_in = 1'b0;
    wait_n(6);
    xfer(8'hA0, 5, mi);
    chk("t4_partial_miso", 32'(mi), 32'hC0);
    ss_n_in = 1'b1;
    wait_n(4);
    chk("t4_oe_off", 32'({miso_oe, busy}), 0);
    chk("t4_no_rx_valid", 32'(rx_valid), 0);
    wait_n(2);
    push_tx(8'h96);
    ss_n_in = 1'b0;
    wait_n(6);
    xfer(8'hE7, 8, mi);
    chk("t4_next_miso", 32'(mi), 32'h96);
    chk("t4_next_rx_data", 32'(rx_data), 32'hE7);
    chk("t4_next_rx_valid", 32'(rx_valid), 1);
    ss_n_in = 1'b1;
    wait_n(5);

    // ---------------- reset mid-frame ----------------
    push_tx(8'h77);
    ss_n_in = 1'b0;
    wait_n(6);
    push_tx(8'h55);
    chk("t5_tx_ready_full", 32'(tx_ready), 0);
    xfer(8'hFF, 3, mi);
    chk("t5_miso_bit3", 32'(miso), 1);
    mosi_in = 1'b1;
    wait_n(2);
    preset_n = 1'b0;
    #1;
    chk("t5_reset_flags", 32'({miso, miso_oe, tx_ready, rx_valid, rx_overrun, tx_underrun, busy}),
        32'b0010000);
    chk("t5_reset_rx_data", 32'(rx_data), 32'h00);
    ss_n_in = 1'b1;
    wait_n(2);
    preset_n = 1'b1;
    wait_n(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
